// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus: two requester ports
// plus the shared memory side and the grant view.
interface dmem_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic        a_lock;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_ack;
  logic [31:0] a_rdata;
  logic        b_req;
  logic        b_we;
  logic        b_lock;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic [31:0] b_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic [1:0]  grant;

  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    input  mem_dout,
    output a_ack, a_rdata, b_ack, b_rdata,
    output mem_we, mem_addr, mem_din, grant
  );

  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    output mem_dout,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  mem_we, mem_addr, mem_din, grant
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin with
// bounded lock retention, one-cycle access slots.
module dmem_arbiter #(
  parameter int LOCK_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ACC_A,
    ACC_B
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          last_b;
  logic [CW-1:0] cnt;
  logic          a_elig;
  logic          b_elig;
  logic          lock_on;
  logic          hold;
  logic          win_a;

  // Arbitration, next state and memory-side outputs.
  // A pending lock keeps the owner's slot free through
  // its own ack cycle so it can win the next round.
  always_comb begin
    a_elig       = bus.a_req & ~bus.a_ack;
    b_elig       = bus.b_req & ~bus.b_ack;
    lock_on      = (cnt != '0);
    hold         = lock_on & (last_b ?
                   (bus.b_ack & a_elig) :
                   (bus.a_ack & b_elig));
    win_a        = lock_on ? ~last_b : last_b;
    state_nx     = state;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    bus.grant    = 2'b00;
    unique case (state)
      IDLE: begin
        if (hold)
          state_nx = IDLE;
        else if (a_elig & (~b_elig | win_a))
          state_nx = ACC_A;
        else if (b_elig)
          state_nx = ACC_B;
      end
      ACC_A: begin
        state_nx     = IDLE;
        bus.mem_we   = bus.a_we & rst;
        bus.mem_addr = bus.a_addr;
        bus.mem_din  = bus.a_wdata;
        bus.grant    = 2'b01;
      end
      ACC_B: begin
        state_nx     = IDLE;
        bus.mem_we   = bus.b_we & rst;
        bus.mem_addr = bus.b_addr;
        bus.mem_din  = bus.b_wdata;
        bus.grant    = 2'b10;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Completion pulses and registered read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.a_ack   <= 1'b0;
      bus.b_ack   <= 1'b0;
      bus.a_rdata <= '0;
      bus.b_rdata <= '0;
    end else begin
      bus.a_ack <= (state == ACC_A);
      bus.b_ack <= (state == ACC_B);
      if (state == ACC_A && !bus.a_we)
        bus.a_rdata <= bus.mem_dout;
      if (state == ACC_B && !bus.b_we)
        bus.b_rdata <= bus.mem_dout;
    end
  end

  // Round-robin pointer and lock run counter;
  // a nonzero count means the last grantee holds the lock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_b <= 1'b1;
      cnt    <= '0;
    end else if (state == ACC_A) begin
      last_b <= 1'b0;
      if (!bus.a_lock)
        cnt <= '0;
      else if (last_b)
        cnt <= CW'(1);
      else if (cnt < LMAX)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
    end else if (state == ACC_B) begin
      last_b <= 1'b1;
      if (!bus.b_lock)
        cnt <= '0;
      else if (!last_b)
        cnt <= CW'(1);
      else if (cnt < LMAX)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small
// behavioural data memory behind the shared port.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   fails = 0;

  logic [31:0] mem [256];

  dmem_arbiter_if bus ();

  dmem_arbiter #(.LOCK_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_dout = mem[bus.mem_addr[7:0]];

  always @(posedge clk) begin
    if (bus.mem_we)
      mem[bus.mem_addr[7:0]] <= bus.mem_din;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  logic [1:0] g27 [8] = '{2'd1, 2'd0, 2'd2, 2'd0,
                          2'd1, 2'd0, 2'd2, 2'd0};
  logic       aa27 [8] = '{0, 1, 0, 0, 0, 1, 0, 0};
  logic       ba27 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  logic [1:0] g28 [17] = '{2'd1, 2'd0, 2'd0,
                           2'd1, 2'd0, 2'd0,
                           2'd1, 2'd0, 2'd0,
                           2'd1, 2'd0, 2'd0,
                           2'd1, 2'd0, 2'd2,
                           2'd0, 2'd1};

  initial begin
    bus.a_req   = 0;
    bus.a_we    = 0;
    bus.a_lock  = 0;
    bus.a_addr  = 0;
    bus.a_wdata = 0;
    bus.b_req   = 0;
    bus.b_we    = 0;
    bus.b_lock  = 0;
    bus.b_addr  = 0;
    bus.b_wdata = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    do_reset();
    chk("rst_grant", bus.grant, 0);
    chk("rst_aack", bus.a_ack, 0);
    chk("rst_back", bus.b_ack, 0);
    chk("rst_ardata", bus.a_rdata, 0);
    chk("rst_brdata", bus.b_rdata, 0);
    chk("rst_we", bus.mem_we, 0);

    // A write 0x55 -> 0x10, then read back
    bus.a_req   = 1;
    bus.a_we    = 1;
    bus.a_addr  = 32'h10;
    bus.a_wdata = 32'h55;
    cyc();
    chk("wr_grant", bus.grant, 1);
    chk("wr_we", bus.mem_we, 1);
    chk("wr_addr", bus.mem_addr, 32'h10);
    chk("wr_din", bus.mem_din, 32'h55);
    chk("wr_ack_early", bus.a_ack, 0);
    cyc();
    chk("wr_ack", bus.a_ack, 1);
    chk("wr_we_off", bus.mem_we, 0);
    chk("wr_idle_addr", bus.mem_addr, 0);
    bus.a_req = 0;
    cyc();
    chk("wr_ack_pulse", bus.a_ack, 0);
    bus.a_req = 1;
    bus.a_we  = 0;
    cyc();
    chk("rd_grant", bus.grant, 1);
    chk("rd_we", bus.mem_we, 0);
    cyc();
    chk("rd_ack", bus.a_ack, 1);
    chk("rd_data", bus.a_rdata, 32'h55);

    // Same port writes 0x99 -> 0x20; rdata holds
    bus.a_we    = 1;
    bus.a_addr  = 32'h20;
    bus.a_wdata = 32'h99;
    cyc();
    chk("wr2_ack_gap", bus.a_ack, 0);
    cyc();
    chk("wr2_grant", bus.grant, 1);
    cyc();
    chk("wr2_ack", bus.a_ack, 1);
    chk("wr2_hold", bus.a_rdata, 32'h55);
    bus.a_req = 0;
    cyc();

    // Full-width address passthrough
    bus.a_req  = 1;
    bus.a_we   = 0;
    bus.a_addr = 32'hDEAD_BEE3;
    cyc();
    chk("addr_full", bus.mem_addr, 32'hDEAD_BEE3);
    cyc();
    bus.a_req = 0;
    cyc();

    // Both requesting out of reset: alternate
    do_reset();
    chk("rst2_ardata", bus.a_rdata, 0);
    bus.a_req  = 1;
    bus.a_we   = 0;
    bus.a_addr = 32'h10;
    bus.b_req  = 1;
    bus.b_we   = 0;
    bus.b_addr = 32'h20;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk($sformatf("rr_grant%0d", k), bus.grant, g27[k]);
      chk($sformatf("rr_aack%0d", k), bus.a_ack, aa27[k]);
      chk($sformatf("rr_back%0d", k), bus.b_ack, ba27[k]);
    end
    chk("rr_ardata", bus.a_rdata, 32'h55);
    chk("rr_brdata", bus.b_rdata, 32'h99);
    bus.a_req = 0;
    bus.b_req = 0;
    cyc();
    chk("rr_drop", bus.grant, 0);
    cyc();

    // Lock held by A with both requesting
    do_reset();
    bus.a_req  = 1;
    bus.a_lock = 1;
    bus.b_req  = 1;
    for (int k = 0; k < 17; k++) begin
      cyc();
      chk($sformatf("lk_grant%0d", k), bus.grant, g28[k]);
    end
    bus.a_req  = 0;
    bus.b_req  = 0;
    bus.a_lock = 0;
    cyc();
    chk("lk_last_ack", bus.a_ack, 1);
    cyc();

    // B write interrupted by reset
    do_reset();
    bus.b_req   = 1;
    bus.b_we    = 1;
    bus.b_addr  = 32'h20;
    bus.b_wdata = 32'hFF;
    cyc();
    chk("int_grant", bus.grant, 2);
    chk("int_we_pre", bus.mem_we, 1);
    rst = 0;
    #1;
    chk("int_we_rst", bus.mem_we, 0);
    cyc();
    chk("int_back", bus.b_ack, 0);
    chk("int_grant2", bus.grant, 0);
    rst = 1;
    bus.b_req = 0;
    cyc();
    chk("int_back2", bus.b_ack, 0);
    bus.b_req = 1;
    bus.b_we  = 0;
    cyc();
    cyc();
    chk("int_rd_ack", bus.b_ack, 1);
    chk("int_rd_data", bus.b_rdata, 32'h99);
    bus.b_req = 0;
    cyc();

    // A pulses req only while B occupies the slot
    bus.b_req  = 1;
    bus.b_addr = 32'h10;
    cyc();
    bus.a_req   = 1;
    bus.a_we    = 1;
    bus.a_addr  = 32'h30;
    bus.a_wdata = 32'h77;
    #1;
    chk("wd_grant", bus.grant, 2);
    chk("wd_addr", bus.mem_addr, 32'h10);
    cyc();
    bus.a_req = 0;
    chk("wd_back", bus.b_ack, 1);
    chk("wd_bdata", bus.b_rdata, 32'h55);
    bus.b_req = 0;
    cyc();
    chk("wd_grant2", bus.grant, 0);
    chk("wd_aack", bus.a_ack, 0);
    cyc();
    chk("wd_aack2", bus.a_ack, 0);
    chk("wd_grant3", bus.grant, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
